// File: rtl/mcu_pkg.sv
// Shared definitions for the DE0 MCU sequencer: FSM states, ALU op codes and
// opcode mask/match pairs, so that the controller and the ALU agree on encodings.
package mcu_pkg;

    localparam int PC_W = 11;
    localparam int IR_W = 14;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_PASS = 4'd5;

    // Opcode field is ir[13:8]; an instruction hits when (opc & MASK) == MATCH.
    localparam logic [5:0] OPC_MOVLW_MASK  = 6'b111100;
    localparam logic [5:0] OPC_MOVLW_MATCH = 6'b110000;
    localparam logic [5:0] OPC_ADDLW_MASK  = 6'b111110;
    localparam logic [5:0] OPC_ADDLW_MATCH = 6'b111110;
    localparam logic [5:0] OPC_SUBLW_MASK  = 6'b111110;
    localparam logic [5:0] OPC_SUBLW_MATCH = 6'b111100;
    localparam logic [5:0] OPC_ANDLW_MASK  = 6'b111111;
    localparam logic [5:0] OPC_ANDLW_MATCH = 6'b111001;
    localparam logic [5:0] OPC_IORLW_MASK  = 6'b111111;
    localparam logic [5:0] OPC_IORLW_MATCH = 6'b111000;
    localparam logic [5:0] OPC_XORLW_MASK  = 6'b111111;
    localparam logic [5:0] OPC_XORLW_MATCH = 6'b111010;
    localparam logic [5:0] OPC_GOTO_MASK   = 6'b111000;
    localparam logic [5:0] OPC_GOTO_MATCH  = 6'b101000;

    function automatic logic opc_hit(input logic [5:0] opc,
                                     input logic [5:0] mask,
                                     input logic [5:0] match);
        return (opc & mask) == match;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps the held instruction to an ALU op,
// a W write request, a GOTO flag and an illegal-opcode flag (state-agnostic).
module instr_decoder
    import mcu_pkg::*;
#(
    parameter int IR_W = 14
) (
    input  logic [IR_W-1:0] i_ir,
    output logic [3:0]      o_alu_op,
    output logic            o_wr_w,
    output logic            o_is_goto,
    output logic            o_illegal
);

    logic [5:0] w_opc;

    assign w_opc = i_ir[IR_W-1:IR_W-6];

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_wr_w    = 1'b0;
        o_is_goto = 1'b0;
        o_illegal = 1'b0;
        if (i_ir == '0) begin
            o_illegal = 1'b0;
        end else if (opc_hit(w_opc, OPC_MOVLW_MASK, OPC_MOVLW_MATCH)) begin
            o_alu_op = ALU_PASS;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_ADDLW_MASK, OPC_ADDLW_MATCH)) begin
            o_alu_op = ALU_ADD;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_SUBLW_MASK, OPC_SUBLW_MATCH)) begin
            o_alu_op = ALU_SUB;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_ANDLW_MASK, OPC_ANDLW_MATCH)) begin
            o_alu_op = ALU_AND;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_IORLW_MASK, OPC_IORLW_MATCH)) begin
            o_alu_op = ALU_OR;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_XORLW_MASK, OPC_XORLW_MATCH)) begin
            o_alu_op = ALU_XOR;
            o_wr_w   = 1'b1;
        end else if (opc_hit(w_opc, OPC_GOTO_MASK, OPC_GOTO_MATCH)) begin
            o_is_goto = 1'b1;
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mcu_controller.sv
// Fetch/decode/execute sequencer: 3 clocks per instruction, synchronous ROM,
// drives ALU op and W load strobe, handles GOTO.
//   state  | meaning
//   FETCH1 | present pc to ROM; wait here while run=0
//   FETCH2 | capture ROM word into IR, pc+1
//   EXEC   | decode IR, strobe W load or take GOTO
module mcu_controller
    import mcu_pkg::*;
#(
    parameter int PC_W = 11,
    parameter int IR_W = 14
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_run,
    input  logic [IR_W-1:0] i_rom_data,
    output logic [PC_W-1:0] o_rom_addr,
    output logic [IR_W-1:0] o_ir_q,
    output logic [3:0]      o_alu_op,
    output logic            o_load_w,
    output logic            o_illegal,
    output logic [1:0]      o_state_q
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [IR_W-1:0] r_ir;
    logic [IR_W-1:0] w_ir_nxt;

    logic [3:0] w_dec_op;
    logic       w_dec_wr;
    logic       w_dec_goto;
    logic       w_dec_ill;

    instr_decoder #(
        .IR_W (IR_W)
    ) u_dec (
        .i_ir      (r_ir),
        .o_alu_op  (w_dec_op),
        .o_wr_w    (w_dec_wr),
        .o_is_goto (w_dec_goto),
        .o_illegal (w_dec_ill)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH1;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = FETCH1;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        o_alu_op    = ALU_ADD;
        o_load_w    = 1'b0;
        o_illegal   = 1'b0;
        case (r_state)
            FETCH1: begin
                w_state_nxt = i_run ? FETCH2 : FETCH1;
            end
            FETCH2: begin
                w_ir_nxt    = i_rom_data;
                w_pc_nxt    = r_pc + PC_W'(1);
                w_state_nxt = EXEC;
            end
            EXEC: begin
                // A reset landing in EXEC must not let W capture anything.
                o_alu_op  = w_dec_op;
                o_load_w  = w_dec_wr & ~i_reset;
                o_illegal = w_dec_ill & ~i_reset;
                if (w_dec_goto) begin
                    w_pc_nxt = r_ir[PC_W-1:0];
                end
                w_state_nxt = FETCH1;
            end
            default: begin
                w_state_nxt = FETCH1;
            end
        endcase
    end

    assign o_rom_addr = r_pc;
    assign o_ir_q     = r_ir;
    assign o_state_q  = r_state;

endmodule

// File: tb/tb_mcu_controller.sv
// Self-checking bench for mcu_controller: directed program then randomized ROM
// and run/reset stimulus, compared every cycle against an instruction-level model.
module tb_mcu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [13:0] rom_data;
    logic [10:0] rom_addr;
    logic [13:0] ir_q;
    logic [3:0]  alu_op;
    logic        load_w;
    logic        illegal;
    logic [1:0]  state_q;

    logic [13:0] rom [2048];
    logic [7:0]  w_dut = 8'h00;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    int          m_ph;
    logic [10:0] m_pc;
    logic [13:0] m_ir;
    logic [7:0]  m_w;

    mcu_controller u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_run      (run),
        .i_rom_data (rom_data),
        .o_rom_addr (rom_addr),
        .o_ir_q     (ir_q),
        .o_alu_op   (alu_op),
        .o_load_w   (load_w),
        .o_illegal  (illegal),
        .o_state_q  (state_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [7:0] alu_ref(input int op, input logic [7:0] k, input logic [7:0] w);
        case (op)
            0:       return k + w;
            1:       return k - w;
            2:       return k & w;
            3:       return k | w;
            4:       return k ^ w;
            default: return k;
        endcase
    endfunction

    // W register as the datapath would hold it, driven only by DUT outputs
    always @(posedge clk) if (load_w === 1'b1) w_dut <= alu_ref(int'(alu_op), ir_q[7:0], w_dut);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mnemonic lookup by numeric opcode ranges
    task automatic ref_decode(input logic [13:0] ir, output int op, output bit wr,
                              output bit go, output bit ill);
        int hi;
        hi  = int'(ir >> 8);
        op  = 0;
        wr  = 1'b0;
        go  = 1'b0;
        ill = 1'b0;
        if (ir == 14'h0000)                 begin end
        else if (hi >= 'h28 && hi <= 'h2F)  go = 1'b1;
        else if (hi >= 'h30 && hi <= 'h33)  begin op = 5; wr = 1'b1; end
        else if (hi >= 'h3E)                begin op = 0; wr = 1'b1; end
        else if (hi == 'h3C || hi == 'h3D)  begin op = 1; wr = 1'b1; end
        else if (hi == 'h39)                begin op = 2; wr = 1'b1; end
        else if (hi == 'h38)                begin op = 3; wr = 1'b1; end
        else if (hi == 'h3A)                begin op = 4; wr = 1'b1; end
        else                                ill = 1'b1;
    endtask

    // One clock: drive inputs at negedge, check, advance model at posedge.
    task automatic step(input bit rst, input bit rn);
        int op;
        bit wr, go, ill;
        int e_op;
        bit e_wr, e_ill;
        reset = rst;
        run   = rn;
        #1;
        ref_decode(m_ir, op, wr, go, ill);
        e_op  = (m_ph == 2) ? op : 0;
        e_wr  = (m_ph == 2) && wr && !rst;
        e_ill = (m_ph == 2) && ill && !rst;
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("state_q",  32'(state_q),  32'(m_ph));
        chk("ir_q",     32'(ir_q),     32'(m_ir));
        chk("alu_op",   32'(alu_op),   32'(e_op));
        chk("load_w",   32'(load_w),   32'(e_wr));
        chk("illegal",  32'(illegal),  32'(e_ill));
        @(posedge clk);
        if (e_wr) m_w = alu_ref(op, m_ir[7:0], m_w);
        if (rst) begin
            m_ph = 0;
            m_pc = '0;
            m_ir = '0;
        end else if (m_ph == 0) begin
            if (rn) m_ph = 1;
        end else if (m_ph == 1) begin
            m_ir = rom[m_pc];
            m_pc = m_pc + 11'd1;
            m_ph = 2;
        end else begin
            if (go) m_pc = m_ir[10:0];
            m_ph = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [13:0] rnd_instr();
        logic [7:0] k;
        k = 8'($urandom);
        case ($urandom_range(0, 8))
            0:       return {6'h30 | 6'($urandom_range(0, 3)), k};
            1:       return {6'h3E | 6'($urandom_range(0, 1)), k};
            2:       return {6'h3C | 6'($urandom_range(0, 1)), k};
            3:       return {6'h39, k};
            4:       return {6'h38, k};
            5:       return {6'h3A, k};
            6:       return {3'b101, 11'($urandom)};
            7:       return 14'h0000;
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 14'h0000;
        rom[0]      = 14'h3055;   // MOVLW 0x55
        rom[1]      = 14'h3E0A;   // ADDLW 0x0A
        rom[2]      = 14'h3C03;   // SUBLW 0x03
        rom[3]      = 14'h3A0F;   // XORLW 0x0F
        rom[4]      = 14'h2FFE;   // GOTO 0x7FE
        rom[11'h7FE] = 14'h0000;  // NOP
        rom[11'h7FF] = 14'h0100;  // unrecognised opcode
        m_ph = 0;
        m_pc = '0;
        m_ir = '0;
        m_w  = 8'h00;

        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // directed program through GOTO 0x7FE, NOP, illegal at 0x7FF, wrap to 0
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 1'b1);
            if (i == 11) chk("w_after_xor", 32'(w_dut), 32'h0000_00AB);
        end

        // stall in FETCH1, then drop run during FETCH2
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // reset landing in EXEC of ADDLW
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rom[4] = 14'h2805;        // GOTO 5
        rom[5] = 14'h3077;        // MOVLW 0x77
        step(1'b1, 1'b1);
        for (int i = 0; i < 21; i++) step(1'b0, 1'b1);
        chk("w_after_goto5", 32'(w_dut), 32'(m_w));

        // randomized ROM and run/reset pattern
        reset = 1'b1;
        for (int a = 0; a < 2048; a++) rom[a] = rnd_instr();
        step(1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 96) == 0, $urandom_range(0, 4) != 0);
            if (i % 50 == 49) chk("w_track", 32'(w_dut), 32'(m_w));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
